// File: rtl/tv80_pkg.sv
// Shared types and helpers for the reduced TV80 core: T-states, CB shift ops, flag layout.
package tv80_pkg;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 16;

   typedef enum logic [1:0] {TS_T1, TS_T2, TS_T3, TS_T4} tstate_e;

   typedef enum logic [2:0] {
      SH_RLC, SH_RRC, SH_RL, SH_RR, SH_SLA, SH_SRA, SH_SLL, SH_SRL
   } shift_op_e;

   localparam int unsigned FLAG_C  = 0;
   localparam int unsigned FLAG_N  = 1;
   localparam int unsigned FLAG_PV = 2;
   localparam int unsigned FLAG_X3 = 3;
   localparam int unsigned FLAG_H  = 4;
   localparam int unsigned FLAG_X5 = 5;
   localparam int unsigned FLAG_Z  = 6;
   localparam int unsigned FLAG_S  = 7;

   // Returns {carry_out, result}.
   function automatic logic [DW:0] shift8(input shift_op_e op, input logic [DW-1:0] d,
                                          input logic cin);
      logic [DW:0] r;
      case (op)
         SH_RLC:  r = {d[7], d[6:0], d[7]};
         SH_RRC:  r = {d[0], d[0], d[7:1]};
         SH_RL:   r = {d[7], d[6:0], cin};
         SH_RR:   r = {d[0], cin, d[7:1]};
         SH_SLA:  r = {d[7], d[6:0], 1'b0};
         SH_SRA:  r = {d[0], d[7], d[7:1]};
         SH_SLL:  r = {d[7], d[6:0], 1'b1};
         default: r = {d[0], 1'b0, d[7:1]};
      endcase
      return r;
   endfunction

   function automatic logic [DW-1:0] shift_flags(input logic [DW:0] cr);
      logic [DW-1:0] f;
      f          = '0;
      f[FLAG_S]  = cr[7];
      f[FLAG_Z]  = (cr[7:0] == 8'h00);
      f[FLAG_X5] = cr[5];
      f[FLAG_X3] = cr[3];
      f[FLAG_PV] = ~^cr[7:0];
      f[FLAG_C]  = cr[8];
      return f;
   endfunction

endpackage

// File: rtl/tv80_core.sv
// M1 sequencer, architectural state and CB shift/rotate execution.
module tv80_core
   import tv80_pkg::*;
(
   input  logic          clk,
   input  logic          reset_n,
   input  logic          cen_i,
   input  logic          wait_n_i,
   input  logic [DW-1:0] di_i,
   output logic          m1_n_o,
   output logic          mreq_n_o,
   output logic          rd_n_o,
   output logic          rfsh_n_o,
   output logic          halt_n_o,
   output logic [AW-1:0] addr_o
);

   logic [AW-1:0] PC, SP, A;
   logic [DW-1:0] ACC, F, Ap, Fp, I, R;
   logic          IntE_FF1, IntE_FF2, Halt_FF, Alternate;

   tstate_e       ts_q;
   logic [DW-1:0] ir_q;
   logic          cb_q;
   logic          m1_q, mreq_q, rd_q, rfsh_q;

   logic [2:0]    rsel;
   logic [DW-1:0] rd_h, rd_l, opnd, sh_flags;
   logic [DW:0]   sh;
   logic          exec_sh, wr_reg;

   // Operand fetch and shifter; A (r=7) lives in the core, the rest in the file.
   always_comb begin
      rsel     = {Alternate, ir_q[2:1]};
      opnd     = (ir_q[2:0] == 3'd7) ? ACC : (ir_q[0] ? rd_l : rd_h);
      sh       = shift8(shift_op_e'(ir_q[5:3]), opnd, F[FLAG_C]);
      sh_flags = shift_flags(sh);
      exec_sh  = cb_q && (ts_q == TS_T4) && (ir_q[7:6] == 2'b00) && (ir_q[2:0] != 3'd6);
      wr_reg   = cen_i && exec_sh && (ir_q[2:0] != 3'd7);
   end

   tv80_reg regs (
      .clk       (clk),
      .we_h_i    (wr_reg & ~ir_q[0]),
      .we_l_i    (wr_reg & ir_q[0]),
      .waddr_i   (rsel),
      .wdata_i   (sh[7:0]),
      .raddr_a_i (rsel),
      .rdata_h_o (rd_h),
      .raddr_b_i (rsel),
      .rdata_l_o (rd_l)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         PC        <= 16'h0000;
         SP        <= 16'hFFFF;
         A         <= 16'h0000;
         ACC       <= 8'hFF;
         F         <= 8'hFF;
         Ap        <= 8'hFF;
         Fp        <= 8'hFF;
         I         <= 8'h00;
         R         <= 8'h00;
         IntE_FF1  <= 1'b0;
         IntE_FF2  <= 1'b0;
         Halt_FF   <= 1'b0;
         Alternate <= 1'b0;
         ts_q      <= TS_T1;
         ir_q      <= 8'h00;
         cb_q      <= 1'b0;
         m1_q      <= 1'b1;
         mreq_q    <= 1'b1;
         rd_q      <= 1'b1;
         rfsh_q    <= 1'b1;
      end else if (cen_i) begin
         case (ts_q)
            TS_T1: begin
               ts_q   <= TS_T2;
               A      <= PC;
               m1_q   <= 1'b0;
               mreq_q <= 1'b0;
               rd_q   <= 1'b0;
               rfsh_q <= 1'b1;
            end
            TS_T2: begin
               if (wait_n_i) begin
                  ts_q   <= TS_T3;
                  // A halted CPU refetches the same address and executes NOPs.
                  ir_q   <= Halt_FF ? 8'h00 : di_i;
                  if (!Halt_FF) PC <= AW'(PC + 16'd1);
                  A      <= {I, R};
                  m1_q   <= 1'b1;
                  rd_q   <= 1'b1;
                  mreq_q <= 1'b0;
                  rfsh_q <= 1'b0;
               end
            end
            TS_T3: ts_q <= TS_T4;
            default: begin
               ts_q   <= TS_T1;
               R      <= {R[7], 7'(R[6:0] + 7'd1)};
               A      <= PC;
               m1_q   <= 1'b0;
               mreq_q <= 1'b0;
               rd_q   <= 1'b0;
               rfsh_q <= 1'b1;
               if (cb_q) begin
                  cb_q <= 1'b0;
                  if (exec_sh) begin
                     F <= sh_flags;
                     if (ir_q[2:0] == 3'd7) ACC <= sh[7:0];
                  end
               end else if (ir_q == 8'hCB) begin
                  cb_q <= 1'b1;
               end else if (ir_q == 8'h76) begin
                  Halt_FF <= 1'b1;
               end
            end
         endcase
      end
   end

   assign m1_n_o   = m1_q;
   assign mreq_n_o = mreq_q;
   assign rd_n_o   = rd_q;
   assign rfsh_n_o = rfsh_q;
   assign halt_n_o = ~Halt_FF;
   assign addr_o   = A;

   logic unused_state;
   assign unused_state = ^{SP, Ap, Fp, IntE_FF1, IntE_FF2};

endmodule

// File: rtl/tv80_reg.sv
// General register file: two banks x {BC,DE,HL,IX/IY}, high/low byte arrays.
module tv80_reg
   import tv80_pkg::*;
(
   input  logic          clk,
   input  logic          we_h_i,
   input  logic          we_l_i,
   input  logic [2:0]    waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [2:0]    raddr_a_i,
   output logic [DW-1:0] rdata_h_o,
   input  logic [2:0]    raddr_b_i,
   output logic [DW-1:0] rdata_l_o
);

   logic [DW-1:0] RegsH [0:7];
   logic [DW-1:0] RegsL [0:7];

   always_ff @(posedge clk) begin
      if (we_h_i) RegsH[waddr_i] <= wdata_i;
      if (we_l_i) RegsL[waddr_i] <= wdata_i;
   end

   assign rdata_h_o = RegsH[raddr_a_i];
   assign rdata_l_o = RegsL[raddr_b_i];

endmodule

// File: rtl/tv80s.sv
// Z80-bus wrapper around the reduced TV80 core; I/O, write and bus-grant paths are idle.
module tv80s
   import tv80_pkg::*;
(
   input  logic          clk,
   input  logic          reset_n,
   input  logic          cen,
   input  logic          wait_n,
   input  logic          int_n,
   input  logic          nmi_n,
   input  logic          busrq_n,
   input  logic [DW-1:0] di,
   output logic          m1_n,
   output logic          mreq_n,
   output logic          iorq_n,
   output logic          rd_n,
   output logic          wr_n,
   output logic          rfsh_n,
   output logic          halt_n,
   output logic          busak_n,
   output logic [AW-1:0] A,
   output logic [DW-1:0] dout
);

   tv80_core core (
      .clk      (clk),
      .reset_n  (reset_n),
      .cen_i    (cen),
      .wait_n_i (wait_n),
      .di_i     (di),
      .m1_n_o   (m1_n),
      .mreq_n_o (mreq_n),
      .rd_n_o   (rd_n),
      .rfsh_n_o (rfsh_n),
      .halt_n_o (halt_n),
      .addr_o   (A)
   );

   assign iorq_n  = 1'b1;
   assign wr_n    = 1'b1;
   assign busak_n = 1'b1;
   assign dout    = '0;

   logic unused_inputs;
   assign unused_inputs = ^{int_n, nmi_n, busrq_n};

endmodule

// File: tb/tb_tv80s.sv
// Directed bench for tv80s: fetch strobes, CB shifts, HALT, clock enable, wait states.
module tb_tv80s;

   logic        clk = 1'b0;
   logic        reset_n, cen, wait_n;
   logic [7:0]  di, dout;
   logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, halt_n, busak_n;
   logic [15:0] A;
   logic [7:0]  mem [0:65535];
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;
   assign di = mem[A];

   tv80s dut (
      .clk(clk), .reset_n(reset_n), .cen(cen), .wait_n(wait_n),
      .int_n(1'b1), .nmi_n(1'b1), .busrq_n(1'b1), .di(di),
      .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
      .rfsh_n(rfsh_n), .halt_n(halt_n), .busak_n(busak_n), .A(A), .dout(dout)
   );

   task automatic apply_reset(input logic [7:0] m0, input logic [7:0] m1);
      cen = 1'b0; wait_n = 1'b1; reset_n = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      mem[0] = m0; mem[1] = m1;
      @(negedge clk); @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic run(input int n);
      cen = 1'b1;
      repeat (n) @(negedge clk);
      cen = 1'b0;
   endtask

   task automatic test_reset;
      cen = 1'b0; wait_n = 1'b1; reset_n = 1'b0;
      @(negedge clk);
      n_cmp++; if (dut.core.PC !== 16'h0000) begin n_bad++; $display("FAIL rst_pc: got %h want 0000", dut.core.PC); end
      n_cmp++; if (dut.core.SP !== 16'hFFFF) begin n_bad++; $display("FAIL rst_sp: got %h want FFFF", dut.core.SP); end
      n_cmp++; if ({dut.core.ACC, dut.core.F} !== 16'hFFFF) begin n_bad++; $display("FAIL rst_af: got %h want FFFF", {dut.core.ACC, dut.core.F}); end
      n_cmp++; if ({dut.core.I, dut.core.R} !== 16'h0000) begin n_bad++; $display("FAIL rst_ir: got %h want 0000", {dut.core.I, dut.core.R}); end
      n_cmp++; if ({m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, halt_n, busak_n} !== 8'hFF) begin
         n_bad++; $display("FAIL rst_strobes: got %b want 11111111", {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, halt_n, busak_n}); end
      n_cmp++; if ({A, dout} !== 24'h000000) begin n_bad++; $display("FAIL rst_bus: got %h want 000000", {A, dout}); end
   endtask

   task automatic test_strobes;
      apply_reset(8'h00, 8'h00);
      dut.core.I = 8'h12; dut.core.R = 8'h34;
      run(1);
      n_cmp++; if ({m1_n, mreq_n, rd_n, rfsh_n, A} !== {4'b0001, 16'h0000}) begin
         n_bad++; $display("FAIL t2_bus: got %b %h want 0001 0000", {m1_n, mreq_n, rd_n, rfsh_n}, A); end
      run(1);
      n_cmp++; if ({m1_n, mreq_n, rd_n, rfsh_n, A} !== {4'b1010, 16'h1234}) begin
         n_bad++; $display("FAIL t3_bus: got %b %h want 1010 1234", {m1_n, mreq_n, rd_n, rfsh_n}, A); end
      n_cmp++; if (dut.core.PC !== 16'h0001) begin n_bad++; $display("FAIL t3_pc: got %h want 0001", dut.core.PC); end
      run(2);
      n_cmp++; if ({m1_n, A, dut.core.R} !== {1'b0, 16'h0001, 8'h35}) begin
         n_bad++; $display("FAIL t1_next: got %b %h R=%h want 0 0001 R=35", m1_n, A, dut.core.R); end
   endtask

   task automatic test_sll_e;
      apply_reset(8'hCB, 8'h33);
      dut.core.ACC = 8'hD5; dut.core.F = 8'h00;
      dut.core.regs.RegsH[0] = 8'h97; dut.core.regs.RegsL[0] = 8'h20;
      dut.core.regs.RegsH[1] = 8'h76; dut.core.regs.RegsL[1] = 8'h44;
      dut.core.regs.RegsH[2] = 8'h03; dut.core.regs.RegsL[2] = 8'h8F;
      run(8);
      n_cmp++; if (dut.core.regs.RegsL[1] !== 8'h89) begin n_bad++; $display("FAIL sll_e: got %h want 89", dut.core.regs.RegsL[1]); end
      n_cmp++; if (dut.core.F !== 8'h88) begin n_bad++; $display("FAIL sll_f: got %h want 88", dut.core.F); end
      n_cmp++; if (dut.core.PC !== 16'h0002) begin n_bad++; $display("FAIL sll_pc: got %h want 0002", dut.core.PC); end
      n_cmp++; if (dut.core.R !== 8'h02) begin n_bad++; $display("FAIL sll_r: got %h want 02", dut.core.R); end
      n_cmp++; if ({dut.core.ACC, dut.core.regs.RegsH[0], dut.core.regs.RegsL[0], dut.core.regs.RegsH[1]} !== 32'hD5972076) begin
         n_bad++; $display("FAIL sll_other: got %h want D5972076",
            {dut.core.ACC, dut.core.regs.RegsH[0], dut.core.regs.RegsL[0], dut.core.regs.RegsH[1]}); end
      n_cmp++; if ({dut.core.regs.RegsH[2], dut.core.regs.RegsL[2]} !== 16'h038F) begin
         n_bad++; $display("FAIL sll_hl: got %h want 038F", {dut.core.regs.RegsH[2], dut.core.regs.RegsL[2]}); end
      n_cmp++; if (halt_n !== 1'b1) begin n_bad++; $display("FAIL sll_halt: got %b want 1", halt_n); end
   endtask

   task automatic test_rlc_b;
      apply_reset(8'hCB, 8'h00);
      dut.core.F = 8'h00; dut.core.regs.RegsH[0] = 8'h80;
      run(8);
      n_cmp++; if ({dut.core.regs.RegsH[0], dut.core.F} !== 16'h0101) begin
         n_bad++; $display("FAIL rlc_b: got %h want 0101", {dut.core.regs.RegsH[0], dut.core.F}); end
   endtask

   task automatic test_srl_a;
      apply_reset(8'hCB, 8'h3F);
      dut.core.ACC = 8'h01; dut.core.F = 8'h00;
      run(8);
      n_cmp++; if ({dut.core.ACC, dut.core.F} !== 16'h0045) begin
         n_bad++; $display("FAIL srl_a: got %h want 0045", {dut.core.ACC, dut.core.F}); end
   endtask

   task automatic test_r_wrap;
      apply_reset(8'hCB, 8'h33);
      dut.core.R = 8'hFF; dut.core.regs.RegsL[1] = 8'h00;
      run(8);
      n_cmp++; if (dut.core.R !== 8'h81) begin n_bad++; $display("FAIL r_wrap: got %h want 81", dut.core.R); end
   endtask

   task automatic test_halt;
      apply_reset(8'h76, 8'h00);
      run(3);
      n_cmp++; if (halt_n !== 1'b1) begin n_bad++; $display("FAIL halt_early: got %b want 1", halt_n); end
      run(5);
      n_cmp++; if ({dut.core.Halt_FF, halt_n} !== 2'b10) begin n_bad++; $display("FAIL halt_ff: got %b want 10", {dut.core.Halt_FF, halt_n}); end
      n_cmp++; if ({dut.core.PC, dut.core.R} !== 24'h000102) begin n_bad++; $display("FAIL halt_pc_r: got %h want 000102", {dut.core.PC, dut.core.R}); end
      run(4);
      n_cmp++; if ({dut.core.PC, dut.core.R} !== 24'h000103) begin n_bad++; $display("FAIL halt_pc_r2: got %h want 000103", {dut.core.PC, dut.core.R}); end
   endtask

   task automatic test_cen_freeze;
      apply_reset(8'hCB, 8'h00);
      dut.core.F = 8'h00; dut.core.regs.RegsH[0] = 8'h80;
      run(2);
      repeat (4) @(negedge clk);
      n_cmp++; if ({dut.core.PC, dut.core.R, m1_n, rfsh_n} !== {16'h0001, 8'h00, 2'b10}) begin
         n_bad++; $display("FAIL cen_hold: got %h %h %b want 0001 00 10", dut.core.PC, dut.core.R, {m1_n, rfsh_n}); end
      run(5);
      n_cmp++; if (dut.core.regs.RegsH[0] !== 8'h80) begin n_bad++; $display("FAIL cen_early: got %h want 80", dut.core.regs.RegsH[0]); end
      run(1);
      n_cmp++; if ({dut.core.regs.RegsH[0], dut.core.F, dut.core.PC} !== 32'h01010002) begin
         n_bad++; $display("FAIL cen_done: got %h want 01010002", {dut.core.regs.RegsH[0], dut.core.F, dut.core.PC}); end
   endtask

   task automatic test_wait;
      apply_reset(8'hCB, 8'h00);
      dut.core.F = 8'h00; dut.core.regs.RegsH[0] = 8'h80;
      run(1);
      wait_n = 1'b0;
      run(2);
      n_cmp++; if ({dut.core.PC, m1_n, rd_n} !== {16'h0000, 2'b00}) begin
         n_bad++; $display("FAIL wait_t2: got %h %b want 0000 00", dut.core.PC, {m1_n, rd_n}); end
      wait_n = 1'b1;
      run(6);
      n_cmp++; if (dut.core.regs.RegsH[0] !== 8'h80) begin n_bad++; $display("FAIL wait_early: got %h want 80", dut.core.regs.RegsH[0]); end
      run(1);
      n_cmp++; if ({dut.core.regs.RegsH[0], dut.core.F, dut.core.PC, dut.core.R} !== 40'h0101000202) begin
         n_bad++; $display("FAIL wait_done: got %h want 0101000202",
            {dut.core.regs.RegsH[0], dut.core.F, dut.core.PC, dut.core.R}); end
   endtask

   task automatic test_reset_abort;
      apply_reset(8'hCB, 8'h00);
      dut.core.F = 8'h00; dut.core.regs.RegsH[0] = 8'h80;
      run(6);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk); @(negedge clk);
      n_cmp++; if ({dut.core.regs.RegsH[0], dut.core.F, dut.core.PC, m1_n} !== {32'h80FF0000, 1'b1}) begin
         n_bad++; $display("FAIL rst_abort: got %h %h %h %b want 80 FF 0000 1",
            dut.core.regs.RegsH[0], dut.core.F, dut.core.PC, m1_n); end
   endtask

   initial begin
      reset_n = 1'b0; cen = 1'b0; wait_n = 1'b1;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      test_reset;
      test_strobes;
      test_sll_e;
      test_rlc_b;
      test_srl_a;
      test_r_wrap;
      test_halt;
      test_cen_freeze;
      test_wait;
      test_reset_abort;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
